// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO pointer synchronisers (w2r and r2w monitors).
// Functions operate on a fixed maximum width; callers zero-extend and truncate.
package fifo_cdc_pkg;

   localparam int MAX_PTRW = 32;

   // Pointer width including the wrap bit.
   function automatic int ptr_width(input int addrsize);
      return addrsize + 1;
   endfunction

   // Zero-extended Gray codes convert correctly: leading zeros stay zero.
   function automatic logic [MAX_PTRW-1:0] gray2bin(input logic [MAX_PTRW-1:0] g);
      logic [MAX_PTRW-1:0] b;
      b[MAX_PTRW-1] = g[MAX_PTRW-1];
      for (int i = MAX_PTRW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int unsigned popcount(input logic [MAX_PTRW-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_PTRW; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchroniser: STAGES back-to-back registers, async active-low reset.
// Generic clock/reset names so the same chain serves either clock domain.
module cdc_sync_chain #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage[k] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_w2r_gray_mon.sv
// Write-to-read Gray pointer synchroniser with binary conversion, read-side occupancy
// and a sticky monitor for non-Gray jumps or impossible occupancy.
module sync_w2r_gray_mon
   import fifo_cdc_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic [ADDRSIZE:0] wptr,
   input  logic [ADDRSIZE:0] rptr_bin,
   input  logic              err_clr,
   output logic [ADDRSIZE:0] rq_wptr,
   output logic [ADDRSIZE:0] rq_wptr_bin,
   output logic [ADDRSIZE:0] rd_avail,
   output logic              wptr_upd,
   output logic              cdc_err
);

   localparam int PTRW = ptr_width(ADDRSIZE);
   localparam int ARMW = $clog2(SYNC_STAGES + 2);
   localparam logic [ARMW-1:0] ARM_DONE = ARMW'(SYNC_STAGES + 1);
   localparam logic [PTRW-1:0] DEPTH    = PTRW'(2 ** ADDRSIZE);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_w2r_gray_mon: SYNC_STAGES=%0d outside legal range 2..4", SYNC_STAGES);
   end

   logic [PTRW-1:0] prev_gray;
   logic [ARMW-1:0] arm_cnt;
   logic            armed;
   logic            gray_jump;
   logic            overrun;
   logic            err_set;

   cdc_sync_chain #(
      .WIDTH  (PTRW),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (wptr),
      .q     (rq_wptr)
   );

   assign rd_avail = rq_wptr_bin - rptr_bin;

   // Checks stay masked until the post-reset 0 -> wptr transfer has fully drained.
   assign armed     = (arm_cnt == ARM_DONE);
   assign gray_jump = popcount(MAX_PTRW'(rq_wptr ^ prev_gray)) > 32'd1;
   assign overrun   = rd_avail > DEPTH;
   assign err_set   = armed & (gray_jump | overrun);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rq_wptr_bin <= '0;
         prev_gray   <= '0;
         wptr_upd    <= 1'b0;
         cdc_err     <= 1'b0;
         arm_cnt     <= '0;
      end else begin
         rq_wptr_bin <= PTRW'(gray2bin(MAX_PTRW'(rq_wptr)));
         prev_gray   <= rq_wptr;
         wptr_upd    <= (rq_wptr != prev_gray);
         if (!armed) begin
            arm_cnt <= arm_cnt + ARMW'(1);
         end
         // A new violation outranks a coincident clear.
         cdc_err     <= err_set | (cdc_err & ~err_clr);
      end
   end

endmodule
